// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_t;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that arrives while decode is stalled.
module fetch_skid_buf
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              clear,
   input  logic              load,
   input  logic              pop,
   input  logic [DATA_W-1:0] load_instr,
   input  logic [ADDR_W-1:0] load_pc_plus4,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              valid
);

   logic [DATA_W-1:0] instr_reg;
   logic [ADDR_W-1:0] pc_plus4_reg;
   logic              valid_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         instr_reg    <= DATA_W'(NOP_INSTR);
         pc_plus4_reg <= '0;
         valid_reg    <= 1'b0;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         instr_reg    <= load_instr;
         pc_plus4_reg <= load_pc_plus4;
         valid_reg    <= 1'b1;
      end else if (pop) begin
         valid_reg <= 1'b0;
      end
   end

   assign instr    = instr_reg;
   assign pc_plus4 = pc_plus4_reg;
   assign valid    = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction-memory handshake and IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        pc_source,
   input  logic              pc_write,
   input  logic              IF_ID_write,
   input  logic              flush,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] IF_ID_instr,
   output logic [ADDR_W-1:0] IF_ID_pc_plus4,
   output logic              IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_bubble_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] drop_target_reg, drop_target_next;
   logic              req_reg, req_next;
   logic [DATA_W-1:0] ifid_instr_reg, ifid_instr_next;
   logic [ADDR_W-1:0] ifid_pc4_reg, ifid_pc4_next;
   logic              ifid_valid_reg, ifid_valid_next;

   logic              accept;
   logic              keep_word;
   logic              bubble;
   logic [ADDR_W-1:0] pc_incr;
   logic [ADDR_W-1:0] redirect_target;

   logic              skid_load, skid_pop, skid_clear;
   logic              skid_valid, skid_full_next;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc4;

   assign accept    = req_reg & imem_ready;
   // A word accepted while dropping, or in a flush cycle, belongs to a squashed path.
   assign keep_word = accept & (state_reg == FETCH) & ~flush;
   assign pc_incr   = pc_reg + ADDR_W'(PC_INCR);

   always_comb begin
      redirect_target = pc_incr;
      case (pc_src_t'(pc_source))
         PC_BRANCH: redirect_target = branch_target;
         PC_JUMP:   redirect_target = jump_target;
         default:   redirect_target = pc_incr;
      endcase
   end

   always_comb begin
      ifid_instr_next = ifid_instr_reg;
      ifid_pc4_next   = ifid_pc4_reg;
      ifid_valid_next = ifid_valid_reg;
      skid_load       = 1'b0;
      skid_pop        = 1'b0;
      skid_clear      = 1'b0;
      bubble          = 1'b0;
      skid_full_next  = skid_valid;

      if (flush) begin
         ifid_valid_next = 1'b0;
         ifid_instr_next = DATA_W'(NOP_INSTR);
         skid_clear      = 1'b1;
         skid_full_next  = 1'b0;
      end else if (!IF_ID_write) begin
         skid_load = keep_word;
         if (keep_word) begin
            skid_full_next = 1'b1;
         end
      end else if (skid_valid) begin
         ifid_instr_next = skid_instr;
         ifid_pc4_next   = skid_pc4;
         ifid_valid_next = 1'b1;
         skid_pop        = 1'b1;
         skid_full_next  = 1'b0;
      end else if (keep_word) begin
         ifid_instr_next = imem_rdata;
         ifid_pc4_next   = pc_incr;
         ifid_valid_next = 1'b1;
      end else begin
         ifid_valid_next = 1'b0;
         bubble          = 1'b1;
      end
   end

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      drop_target_next = drop_target_reg;
      req_next         = req_reg;

      case (state_reg)
         FETCH: begin
            if (flush && req_reg && !imem_ready) begin
               state_next       = DROP;
               drop_target_next = redirect_target;
            end else if (flush) begin
               pc_next = redirect_target;
            end else if (accept) begin
               pc_next = pc_incr;
            end
         end
         DROP: begin
            if (accept) begin
               pc_next    = flush ? redirect_target : drop_target_reg;
               state_next = FETCH;
            end else if (flush) begin
               drop_target_next = redirect_target;
            end
         end
         default: state_next = FETCH;
      endcase

      // The request line only changes once the outstanding one has been accepted.
      if (!req_reg || imem_ready) begin
         req_next = pc_write & ~skid_full_next & (state_next == FETCH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= FETCH;
         pc_reg          <= ADDR_W'(RESET_PC);
         drop_target_reg <= ADDR_W'(RESET_PC);
         req_reg         <= 1'b0;
         ifid_instr_reg  <= DATA_W'(NOP_INSTR);
         ifid_pc4_reg    <= '0;
         ifid_valid_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         drop_target_reg <= drop_target_next;
         req_reg         <= req_next;
         ifid_instr_reg  <= ifid_instr_next;
         ifid_pc4_reg    <= ifid_pc4_next;
         ifid_valid_reg  <= ifid_valid_next;
      end
   end

   fetch_skid_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk           (clk),
      .srst          (rst),
      .clear         (skid_clear),
      .load          (skid_load),
      .pop           (skid_pop),
      .load_instr    (imem_rdata),
      .load_pc_plus4 (pc_incr),
      .instr         (skid_instr),
      .pc_plus4      (skid_pc4),
      .valid         (skid_valid)
   );

   assign imem_req       = req_reg;
   assign imem_addr      = pc_reg;
   assign IF_ID_instr    = ifid_instr_reg;
   assign IF_ID_pc_plus4 = ifid_pc4_reg;
   assign IF_ID_valid    = ifid_valid_reg;

`ifdef FETCH_PERF_CNT_EN
   logic [1:0] perf_evt;
   assign perf_evt = {flush, bubble};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_perf
         logic [31:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (perf_evt[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end
      end
   endgenerate

   assign perf_bubble_cnt = g_perf[0].cnt_reg;
   assign perf_flush_cnt  = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan sequence, then randomized
// hazard commands and memory latency against a queue-based reference model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_source;
   logic        pc_write;
   logic        IF_ID_write;
   logic        flush;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_pc_plus4;
   logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubble_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .ADDR_W   (32),
      .DATA_W   (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_source      (pc_source),
      .pc_write       (pc_write),
      .IF_ID_write    (IF_ID_write),
      .flush          (flush),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .IF_ID_instr    (IF_ID_instr),
      .IF_ID_pc_plus4 (IF_ID_pc_plus4),
      .IF_ID_valid    (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: state as it must be after the next rising edge.
   logic [31:0] m_pc, m_dtgt, m_instr, m_pc4, m_bub, m_fl;
   logic        m_req, m_drop, m_valid;
   logic [63:0] m_skid[$];

   // Memory environment.
   int lat_mode;
   int lat;
   int wcnt;
   bit force_ready;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         default: return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
      endcase
   endfunction

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_dtgt  = RESET_PC;
      m_req   = 1'b0;
      m_drop  = 1'b0;
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_bub   = 32'h0;
      m_fl    = 32'h0;
      m_skid.delete();
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic pw, input logic iw, input logic fl,
                        input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt);
      logic        rdy;
      logic        acc;
      logic [31:0] word;
      logic [31:0] tgt;
      logic [63:0] e;
      @(negedge clk);
      check("imem_req", 64'(imem_req), 64'(m_req));
      check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("IF_ID_valid", 64'(IF_ID_valid), 64'(m_valid));
      check("IF_ID_instr", 64'(IF_ID_instr), 64'(m_instr));
      if (m_valid) check("IF_ID_pc_plus4", 64'(IF_ID_pc_plus4), 64'(m_pc4));
`ifdef FETCH_PERF_CNT_EN
      check("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(m_bub));
      check("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_fl));
`endif

      rst           = r;
      pc_write      = pw;
      IF_ID_write   = iw;
      flush         = fl;
      pc_source     = src;
      branch_target = bt;
      jump_target   = jt;

      if (force_ready)   rdy = 1'b1;
      else if (imem_req) rdy = (wcnt >= lat);
      else               rdy = 1'b0;
      if (r) begin
         wcnt = 0;
      end else if (imem_req && rdy) begin
         wcnt = 0;
         lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
         $display("fetch addr=%h data=%h%s", imem_addr, mem_word(imem_addr), fl ? " (squashed)" : "");
      end else if (imem_req) begin
         wcnt++;
      end
      imem_ready = rdy;
      imem_rdata = mem_word(imem_addr);

      if (r) begin
         model_reset();
      end else begin
         acc  = m_req && rdy;
         word = mem_word(m_pc);
         tgt  = (src == 2'b01) ? bt : (src == 2'b10) ? jt : m_pc + 32'd4;
         if (fl) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_skid.delete();
            if (m_fl != 32'hFFFF_FFFF) m_fl++;
         end else if (!iw) begin
            if (acc && !m_drop) m_skid.push_back({word, m_pc + 32'd4});
         end else if (m_skid.size() > 0) begin
            e       = m_skid.pop_front();
            m_instr = e[63:32];
            m_pc4   = e[31:0];
            m_valid = 1'b1;
         end else if (acc && !m_drop) begin
            m_instr = word;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
            if (m_bub != 32'hFFFF_FFFF) m_bub++;
         end

         if (m_drop) begin
            if (acc) begin
               m_pc   = fl ? tgt : m_dtgt;
               m_drop = 1'b0;
            end else if (fl) begin
               m_dtgt = tgt;
            end
         end else if (fl && m_req && !rdy) begin
            m_drop = 1'b1;
            m_dtgt = tgt;
         end else if (fl) begin
            m_pc = tgt;
         end else if (acc) begin
            m_pc = m_pc + 32'd4;
         end

         if (acc) m_req = 1'b0;
         if (!m_req && pw && m_skid.size() == 0 && !m_drop) m_req = 1'b1;
      end
   endtask

   task automatic run(input logic pw, input logic iw, input logic fl, input logic [1:0] src,
                      input logic [31:0] bt, input logic [31:0] jt);
      cycle(1'b0, pw, iw, fl, src, bt, jt);
   endtask

   initial begin
      logic [31:0] bt, jt;
      rst = 1'b1; pc_source = 2'b00; pc_write = 1'b0; IF_ID_write = 1'b0; flush = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
      lat_mode = 0; lat = 0; wcnt = 0; force_ready = 1'b0;
      model_reset();

      cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      run(1, 1, 0, 2'b00, 0, 0);
      check("reset req", 64'(imem_req), 64'h0);
      check("reset valid", 64'(IF_ID_valid), 64'h0);
      check("reset instr", 64'(IF_ID_instr), 64'h0);
      check("reset pc_plus4", 64'(IF_ID_pc_plus4), 64'h0);
      check("reset addr", 64'(imem_addr), 64'(RESET_PC));
      run(1, 1, 0, 2'b00, 0, 0);
      check("first req", 64'(imem_req), 64'h1);
      check("first addr", 64'(imem_addr), 64'h0);
      run(1, 1, 0, 2'b00, 0, 0);
      check("seq addr4", 64'(imem_addr), 64'h4);
      check("seq instr 0x11", 64'(IF_ID_instr), 64'h11);
      check("seq pc4 4", 64'(IF_ID_pc_plus4), 64'h4);
      // Stall three cycles while the fetch of address 8 completes.
      run(0, 0, 0, 2'b00, 0, 0);
      check("stall addr8", 64'(imem_addr), 64'h8);
      run(0, 0, 0, 2'b00, 0, 0);
      check("stall no req", 64'(imem_req), 64'h0);
      check("stall hold", 64'(IF_ID_instr), 64'h22);
      run(0, 0, 0, 2'b00, 0, 0);
      run(1, 1, 0, 2'b00, 0, 0);
      check("release hold", 64'(IF_ID_instr), 64'h22);
      run(1, 1, 0, 2'b00, 0, 0);
      check("skid instr", 64'(IF_ID_instr), 64'h33);
      check("skid pc4", 64'(IF_ID_pc_plus4), 64'hC);
      check("req 0xC", 64'(imem_addr), 64'hC);
      // Branch flush with zero-wait memory.
      run(1, 1, 1, 2'b01, 32'h100, 0);
      lat_mode = 3;
      run(1, 1, 0, 2'b00, 0, 0);
      check("flush valid", 64'(IF_ID_valid), 64'h0);
      check("branch addr", 64'(imem_addr), 64'h100);
      run(1, 1, 0, 2'b00, 0, 0);
      check("branch instr", 64'(IF_ID_instr), 64'(mem_word(32'h100)));
      check("branch pc4", 64'(IF_ID_pc_plus4), 64'h104);
      // Jump flush during a 3-cycle wait.
      run(1, 1, 1, 2'b10, 0, 32'h200);
      check("drop addr", 64'(imem_addr), 64'h104);
      run(1, 1, 0, 2'b00, 0, 0);
      check("drop hold", 64'(imem_addr), 64'h104);
      lat_mode = 0;
      run(1, 1, 0, 2'b00, 0, 0);
      check("drop resp", 64'(imem_addr), 64'h104);
      run(1, 1, 0, 2'b00, 0, 0);
      check("jump addr", 64'(imem_addr), 64'h200);
      check("drop discarded", 64'(IF_ID_valid), 64'h0);
      // Reset in the middle of an outstanding request with a late ready.
      lat = 3;
      run(1, 1, 0, 2'b00, 0, 0);
      check("jump instr", 64'(IF_ID_instr), 64'(mem_word(32'h200)));
      force_ready = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      force_ready = 1'b0;
      lat = 0;
      run(1, 1, 0, 2'b00, 0, 0);
      check("mid rst req", 64'(imem_req), 64'h0);
      check("mid rst valid", 64'(IF_ID_valid), 64'h0);
      check("mid rst instr", 64'(IF_ID_instr), 64'h0);
      run(1, 1, 0, 2'b00, 0, 0);
      check("post rst addr", 64'(imem_addr), 64'(RESET_PC));
      check("post rst req", 64'(imem_req), 64'h1);
      // PC wrap.
      run(1, 1, 1, 2'b10, 0, 32'hFFFF_FFFC);
      run(1, 1, 0, 2'b00, 0, 0);
      check("wrap top", 64'(imem_addr), 64'hFFFF_FFFC);
      run(1, 1, 0, 2'b00, 0, 0);
      check("wrap addr", 64'(imem_addr), 64'h0);
      check("wrap pc4", 64'(IF_ID_pc_plus4), 64'h0);

      // Randomized phase.
      lat_mode = -1;
      lat = int'($urandom_range(0, 3));
      for (int i = 0; i < 1500; i++) begin
         bt = $urandom & 32'hFFFF_FFFC;
         jt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) jt = 32'hFFFF_FFF0 | (jt & 32'hC);
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 9) == 0),
               2'($urandom_range(0, 3)), bt, jt);
      end
      run(1, 1, 0, 2'b00, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer end of the hazard-control interface: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Executes the pc_source / pc_write / IF_ID_write / flush commands issued by the hazard unit.
- Sits between instruction memory and the ID stage; guarantees that a squashed or stalled fetch never reaches decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_source  in  2  00 sequential, 01 branch, 10 jump, 11 reserved (treated as 00).
- pc_write  in  1  0 = do not launch a new fetch.
- IF_ID_write  in  1  0 = hold IF/ID contents.
- flush  in  1  squash IF/ID and redirect the PC.
- branch_target  in  ADDR_W  redirect address for pc_source=01.
- jump_target  in  ADDR_W  redirect address for pc_source=10.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_ready  in  1  memory response valid this cycle; imem_rdata is valid with it.
- imem_rdata  in  DATA_W  fetched instruction.
- IF_ID_instr  out  DATA_W  decode-stage instruction.
- IF_ID_pc_plus4  out  ADDR_W  address of the IF_ID_instr word + 4.
- IF_ID_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = FETCH; imem_req = 0.
  - IF_ID_instr = 0 (NOP), IF_ID_pc_plus4 = 0, IF_ID_valid = 0.
  - Skid buffer is empty.
  - First request is issued in the cycle after rst deasserts.
  - rst asserted mid-handshake abandons the outstanding request; a late imem_ready is ignored while rst is high.
- Handshake:
  - imem_addr = pc.
  - Once imem_req rises it stays high, with imem_addr stable, until the cycle imem_ready=1. That cycle is the accept.
  - A new request launches only when pc_write=1, the skid buffer is empty and state=FETCH.
  - Zero-wait memory (imem_ready in the same cycle as imem_req) allows one fetch per cycle.
- PC update:
  - On accept: pc <= pc+4, modulo 2^ADDR_W, so the PC wraps from FFFF_FFFC to 0.
  - On flush: pc <= target. target = branch_target if pc_source=01, jump_target if pc_source=10, otherwise pc+4.
- IF/ID update, evaluated in priority order:
  1. flush=1: IF_ID_valid <= 0, IF_ID_instr <= 0, skid buffer cleared. flush overrides IF_ID_write=0.
  2. IF_ID_write=0: hold all IF/ID outputs. An accept in this cycle is captured into the one-entry skid buffer together with its pc+4.
  3. Skid buffer full: load from the buffer, then clear it.
  4. Accept: load imem_rdata and pc+4, IF_ID_valid <= 1.
  5. Otherwise: insert a bubble (IF_ID_valid <= 0).
- States:
  - FETCH: normal operation.
  - DROP: entered when flush arrives while imem_req=1 and imem_ready=0.
    - The redirect target is latched; pc is not overwritten.
    - The request is held until imem_ready. That response is discarded (no IF/ID write, no buffer write).
    - Next cycle: pc <= latched target, state -> FETCH.
    - A second flush while in DROP replaces the latched target.
  - flush in the same cycle as imem_ready: the accepted word is discarded, the redirect applies directly and state stays FETCH.
- Latency: with zero-wait memory, the redirect target's instruction appears in IF/ID 2 cycles after the flush cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_bubble_cnt and perf_flush_cnt.
  - perf_bubble_cnt increments on every IF/ID bubble load.
  - perf_flush_cnt increments on every flush cycle.
  - Both reset to 0, saturate at FFFF_FFFF and update synchronously.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - pc_src_t enum: PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10.
  - fetch_state_t enum: FETCH, DROP.
  - NOP_INSTR constant (32'h0).
  - PC_INCR constant (4).
- Sub-module fetch_skid_buf: one-entry {instr, pc_plus4, valid} buffer with load, pop and clear inputs.

Test Plan:
- Reset, then zero-wait memory returning 0x11, 0x22, 0x33: imem_addr steps 0, 4, 8; IF/ID shows 0x11 / pc_plus4 4 the cycle after the first accept.
- Stall (pc_write=0, IF_ID_write=0) for 3 cycles while a fetch of addr 8 completes: IF/ID holds its value, the word goes to the skid buffer, no new request; after release IF/ID loads the buffered word, then the request for 0xC issues.
- flush with pc_source=01, branch_target 0x100, zero-wait memory: IF_ID_valid=0 next cycle; next imem_addr=0x100; its instruction reaches IF/ID 2 cycles after the flush.
- Memory latency 3 cycles, flush with pc_source=10, jump_target 0x200 on cycle 1 of the wait: addr stays stable until imem_ready, the response is dropped, then imem_addr=0x200.
- pc = FFFF_FFFC accepted: next imem_addr = 0.
- rst pulse during an outstanding request: all outputs return to reset values; a late imem_ready is ignored; the next fetch address is RESET_PC.
